// File: rtl/spi_word_packer.sv
// spi_word_packer: packs the SPI receiver's byte stream into WORD_WIDTH-bit
// words and presents each word on a valid/ready handshake. A partial frame is
// dropped after TIMEOUT_CYCLES idle cycles. A byte that arrives while a word
// is still waiting for the consumer is dropped and flagged.
// Optional feature: define SPI_WORD_PACKER_CHECKSUM_EN to expect a trailing
// XOR checksum byte after the data bytes of every frame.
module spi_word_packer #(
  parameter int unsigned WORD_WIDTH     = 64,
  parameter bit          MSB_FIRST      = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 100_000
) (
  input  logic                                clk_in,
  input  logic                                rst_in,
  input  logic [7:0]                          data_in,
  input  logic                                valid_in,
  input  logic                                ready_in,
  output logic [WORD_WIDTH-1:0]               word_out,
  output logic                                word_valid_out,
  output logic [$clog2(WORD_WIDTH/8+2)-1:0]   byte_count_out,
  output logic                                busy_out,
  output logic                                timeout_out,
  output logic                                overflow_out,
  output logic                                checksum_err_out
);

  localparam int unsigned BYTES = WORD_WIDTH / 8;
  localparam int unsigned CNT_W = $clog2(BYTES + 2);
  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES);
`ifdef SPI_WORD_PACKER_CHECKSUM_EN
  localparam int unsigned FRAME_LEN = BYTES + 1;
`else
  localparam int unsigned FRAME_LEN = BYTES;
`endif
  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(BYTES);
  localparam logic [TMR_W-1:0] TMR_LAST   = TMR_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    HOLD
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [TMR_W-1:0]      timer_q, timer_d;
  logic [WORD_WIDTH-1:0] buf_q, buf_d;
  logic [WORD_WIDTH-1:0] word_q, word_d;
  logic                  wvalid_q, wvalid_d;
  logic                  tout_q, tout_d;
  logic                  ovf_q, ovf_d;
  logic                  accept;
  logic [CNT_W-1:0]      slot;
`ifdef SPI_WORD_PACKER_CHECKSUM_EN
  logic [7:0]            csum_q, csum_d;
  logic                  cerr_q, cerr_d;
`endif

  // Place byte b into slot idx of w, honouring the byte ordering.
  function automatic logic [WORD_WIDTH-1:0] put_slot(
    input logic [WORD_WIDTH-1:0] w,
    input logic [CNT_W-1:0]      idx,
    input logic [7:0]            b
  );
    logic [WORD_WIDTH-1:0] r;
    r = w;
    for (int unsigned i = 0; i < BYTES; i++) begin
      if (idx == CNT_W'(i)) begin
        if (MSB_FIRST) r[WORD_WIDTH-8-8*i +: 8] = b;
        else           r[8*i +: 8]              = b;
      end
    end
    return r;
  endfunction

  // Next-state, datapath and pulse computation.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    timer_d  = timer_q;
    buf_d    = buf_q;
    word_d   = word_q;
    wvalid_d = wvalid_q;
    tout_d   = 1'b0;
    ovf_d    = 1'b0;
    accept   = 1'b0;
    slot     = '0;
`ifdef SPI_WORD_PACKER_CHECKSUM_EN
    csum_d   = csum_q;
    cerr_d   = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
        if (valid_in) begin
          accept = 1'b1;
          slot   = '0;
        end
      end
      COLLECT: begin
        if (valid_in) begin
          accept = 1'b1;
          slot   = count_q;
        end else if (timer_q == TMR_LAST) begin
          state_d = IDLE;
          count_d = '0;
          timer_d = '0;
          tout_d  = 1'b1;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      HOLD: begin
        if (ready_in) begin
          wvalid_d = 1'b0;
          count_d  = '0;
          state_d  = IDLE;
          if (valid_in) accept = 1'b1;
        end else if (valid_in) begin
          ovf_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Accepting a byte overrides the handshake's return to IDLE so that a
    // byte on the consume cycle starts the next frame.
    if (accept) begin
      timer_d = '0;
`ifdef SPI_WORD_PACKER_CHECKSUM_EN
      if (slot == FRAME_LAST) begin
        if (data_in == csum_q) begin
          word_d   = buf_q;
          wvalid_d = 1'b1;
          count_d  = CNT_FULL;
          state_d  = HOLD;
        end else begin
          cerr_d  = 1'b1;
          count_d = '0;
          state_d = IDLE;
        end
      end else begin
        buf_d   = put_slot(buf_q, slot, data_in);
        csum_d  = (slot == '0) ? data_in : (csum_q ^ data_in);
        count_d = slot + CNT_W'(1);
        state_d = COLLECT;
      end
`else
      if (slot == FRAME_LAST) begin
        word_d   = put_slot(buf_q, slot, data_in);
        wvalid_d = 1'b1;
        count_d  = CNT_FULL;
        state_d  = HOLD;
      end else begin
        buf_d   = put_slot(buf_q, slot, data_in);
        count_d = slot + CNT_W'(1);
        state_d = COLLECT;
      end
`endif
    end
  end

  // State, datapath and pulse registers.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q  <= IDLE;
      count_q  <= '0;
      timer_q  <= '0;
      buf_q    <= '0;
      word_q   <= '0;
      wvalid_q <= 1'b0;
      tout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      timer_q  <= timer_d;
      buf_q    <= buf_d;
      word_q   <= word_d;
      wvalid_q <= wvalid_d;
      tout_q   <= tout_d;
      ovf_q    <= ovf_d;
    end
  end

`ifdef SPI_WORD_PACKER_CHECKSUM_EN
  // Running checksum and mismatch pulse.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      csum_q <= '0;
      cerr_q <= 1'b0;
    end else begin
      csum_q <= csum_d;
      cerr_q <= cerr_d;
    end
  end

  assign checksum_err_out = cerr_q;
`else
  assign checksum_err_out = 1'b0;
`endif

  assign word_out       = word_q;
  assign word_valid_out = wvalid_q;
  assign byte_count_out = count_q;
  assign busy_out       = (state_q == COLLECT);
  assign timeout_out    = tout_q;
  assign overflow_out   = ovf_q;

endmodule

// File: tb/tb_spi_word_packer.sv
// Scoreboard bench for spi_word_packer: one MSB-first and one LSB-first
// instance (32-bit words, 16-cycle timeout) share the same byte stream.
module tb_spi_word_packer;

  logic        clk_100mhz;
  logic        rst;
  logic [7:0]  data;
  logic        valid;
  logic        ready;

  logic [31:0] w_m, w_l;
  logic        wv_m, wv_l;
  logic [2:0]  cnt_m, cnt_l;
  logic        busy_m, busy_l, to_m, to_l, ovf_m, ovf_l, ce_m, ce_l;

  int total = 0;
  int bad   = 0;
  int to_cnt_m = 0, to_cnt_l = 0, ovf_cnt_m = 0, ovf_cnt_l = 0, ce_cnt_m = 0, ce_cnt_l = 0;
  logic [31:0] q_m[$];
  logic [31:0] q_l[$];
  logic prev_m = 1'b0, prev_l = 1'b0;

  spi_word_packer #(.WORD_WIDTH(32), .MSB_FIRST(1'b1), .TIMEOUT_CYCLES(16)) dut_m (
    .clk_in(clk_100mhz), .rst_in(rst), .data_in(data), .valid_in(valid), .ready_in(ready),
    .word_out(w_m), .word_valid_out(wv_m), .byte_count_out(cnt_m), .busy_out(busy_m),
    .timeout_out(to_m), .overflow_out(ovf_m), .checksum_err_out(ce_m)
  );

  spi_word_packer #(.WORD_WIDTH(32), .MSB_FIRST(1'b0), .TIMEOUT_CYCLES(16)) dut_l (
    .clk_in(clk_100mhz), .rst_in(rst), .data_in(data), .valid_in(valid), .ready_in(ready),
    .word_out(w_l), .word_valid_out(wv_l), .byte_count_out(cnt_l), .busy_out(busy_l),
    .timeout_out(to_l), .overflow_out(ovf_l), .checksum_err_out(ce_l)
  );

  initial clk_100mhz = 1'b0;
  always #5 clk_100mhz = ~clk_100mhz;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Inputs change 1 ns after the rising edge; each task returns at that point.
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_100mhz);
      #1;
    end
  endtask

  task automatic strobe(input logic [7:0] b);
    data  = b;
    valid = 1'b1;
    @(posedge clk_100mhz);
    #1;
    valid = 1'b0;
  endtask

  task automatic push_exp(input logic [31:0] w);
    q_m.push_back(w);
    q_l.push_back({w[7:0], w[15:8], w[23:16], w[31:24]});
  endtask

  // Send bytes first..3 of w (first byte = w[31:24]) plus the checksum byte
  // when the feature is built in.
  task automatic send_bytes(input logic [31:0] w, input int first, input int gap, input bit chk_cnt);
    logic [7:0] b;
    logic [7:0] cs;
    cs = w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
    for (int i = first; i < 4; i++) begin
      b = w[31-8*i -: 8];
      strobe(b);
      if (chk_cnt) chk($sformatf("byte_count_step%0d", i + 1), 64'(cnt_m), 64'(i + 1));
      if (i < 3) idle(gap);
    end
`ifdef SPI_WORD_PACKER_CHECKSUM_EN
    idle(gap);
    strobe(cs);
`else
    b = cs;
`endif
  endtask

  // Monitor: pops and compares on each rising word_valid_out; tallies pulse cycles.
  always @(negedge clk_100mhz) begin
    if (rst) begin
      prev_m = 1'b0;
      prev_l = 1'b0;
    end else begin
      if (wv_m && !prev_m) begin
        if (q_m.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_word_m: actual=%0h required=none", w_m);
        end else chk("word_m", 64'(w_m), 64'(q_m.pop_front()));
      end
      if (wv_l && !prev_l) begin
        if (q_l.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_word_l: actual=%0h required=none", w_l);
        end else chk("word_l", 64'(w_l), 64'(q_l.pop_front()));
      end
      prev_m = wv_m;
      prev_l = wv_l;
      to_cnt_m  += int'(to_m);
      to_cnt_l  += int'(to_l);
      ovf_cnt_m += int'(ovf_m);
      ovf_cnt_l += int'(ovf_l);
      ce_cnt_m  += int'(ce_m);
      ce_cnt_l  += int'(ce_l);
    end
  end

  initial begin
    int base_m, base_l;
    rst   = 1'b1;
    valid = 1'b0;
    ready = 1'b1;
    data  = 8'h00;
    #3;
    chk("reset_m", 64'({w_m, wv_m, cnt_m, busy_m, to_m, ovf_m, ce_m}), 64'h0);
    chk("reset_l", 64'({w_l, wv_l, cnt_l, busy_l, to_l, ovf_l, ce_l}), 64'h0);
    @(posedge clk_100mhz);
    #1;
    rst = 1'b0;
    idle(2);

    // Basic packing, both byte orders, ready held high.
    push_exp(32'hDEADBEEF);
    send_bytes(32'hDEADBEEF, 0, 3, 1'b1);
    chk("deadbeef_valid", 64'(wv_m), 64'h1);
    chk("deadbeef_count", 64'(cnt_m), 64'd4);
    chk("deadbeef_valid_l", 64'(wv_l), 64'h1);
    idle(1);
    chk("deadbeef_valid_drop", 64'(wv_m), 64'h0);
    chk("deadbeef_count_zero", 64'(cnt_m), 64'h0);
    chk("deadbeef_kept_l", 64'(w_l), 64'hEFBEADDE);
    idle(3);

    // Partial frame timeout.
    base_m = to_cnt_m;
    base_l = to_cnt_l;
    strobe(8'h11);
    idle(1);
    strobe(8'h22);
    idle(15);
    chk("pre_timeout_count", 64'(cnt_m), 64'd2);
    chk("pre_timeout_pulse", 64'(to_m), 64'h0);
    idle(1);
    chk("timeout_pulse", 64'(to_m), 64'h1);
    chk("timeout_count", 64'(cnt_m), 64'h0);
    chk("timeout_busy", 64'(busy_m), 64'h0);
    idle(3);
    chk("timeout_single_m", 64'(to_cnt_m - base_m), 64'd1);
    chk("timeout_single_l", 64'(to_cnt_l - base_l), 64'd1);
    chk("timeout_no_valid", 64'(wv_m), 64'h0);

    // A byte on the would-be timeout cycle is accepted.
    base_m = to_cnt_m;
    push_exp(32'h01020304);
    strobe(8'h01);
    idle(15);
    send_bytes(32'h01020304, 1, 0, 1'b0);
    chk("edge_byte_valid", 64'(wv_m), 64'h1);
    idle(2);
    chk("edge_byte_no_timeout", 64'(to_cnt_m - base_m), 64'd0);

    // Hold with ready low, overflow, then handshake with a byte on the same cycle.
    ready = 1'b0;
    push_exp(32'hCAFEF00D);
    send_bytes(32'hCAFEF00D, 0, 1, 1'b0);
    idle(2);
    chk("hold_valid", 64'(wv_m), 64'h1);
    base_m = ovf_cnt_m;
    base_l = ovf_cnt_l;
    strobe(8'h55);
    chk("overflow_pulse", 64'(ovf_m), 64'h1);
    idle(2);
    chk("overflow_single_m", 64'(ovf_cnt_m - base_m), 64'd1);
    chk("overflow_single_l", 64'(ovf_cnt_l - base_l), 64'd1);
    chk("hold_word_m", 64'(w_m), 64'hCAFEF00D);
    chk("hold_word_l", 64'(w_l), 64'h0DF0FECA);
    chk("hold_count", 64'(cnt_m), 64'd4);
    push_exp(32'hA1B2C3D4);
    ready = 1'b1;
    data  = 8'hA1;
    valid = 1'b1;
    @(posedge clk_100mhz);
    #1;
    valid = 1'b0;
    chk("handshake_valid_drop", 64'(wv_m), 64'h0);
    chk("handshake_count", 64'(cnt_m), 64'd1);
    chk("handshake_busy", 64'(busy_m), 64'h1);
    chk("handshake_word_kept", 64'(w_m), 64'hCAFEF00D);
    send_bytes(32'hA1B2C3D4, 1, 1, 1'b0);
    idle(2);
    chk("a1_consumed", 64'(wv_m), 64'h0);

    // Asynchronous reset mid-frame.
    strobe(8'h77);
    strobe(8'h88);
    #2;
    rst = 1'b1;
    #1;
    chk("async_reset_m", 64'({w_m, wv_m, cnt_m, busy_m, to_m, ovf_m, ce_m}), 64'h0);
    chk("async_reset_l", 64'({w_l, wv_l, cnt_l, busy_l, to_l, ovf_l, ce_l}), 64'h0);
    #2;
    rst = 1'b0;
    @(posedge clk_100mhz);
    #1;
    push_exp(32'h10111213);
    send_bytes(32'h10111213, 0, 1, 1'b0);
    idle(2);

`ifdef SPI_WORD_PACKER_CHECKSUM_EN
    // Checksum match and mismatch.
    push_exp(32'h01020304);
    send_bytes(32'h01020304, 0, 1, 1'b0);
    idle(2);
    base_m = ce_cnt_m;
    base_l = ce_cnt_l;
    for (int i = 1; i <= 5; i++) strobe(8'(i));
    chk("csum_err_pulse", 64'(ce_m), 64'h1);
    chk("csum_err_no_valid", 64'(wv_m), 64'h0);
    chk("csum_err_count", 64'(cnt_m), 64'h0);
    idle(2);
    chk("csum_err_single_m", 64'(ce_cnt_m - base_m), 64'd1);
    chk("csum_err_single_l", 64'(ce_cnt_l - base_l), 64'd1);
`else
    chk("csum_tied_low", 64'(ce_cnt_m + ce_cnt_l), 64'd0);
`endif

    idle(4);
    chk("queue_m_empty", 64'(q_m.size()), 64'd0);
    chk("queue_l_empty", 64'(q_l.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_word_packer.md
Name: spi_word_packer

Overview:
- Downstream of the SPI peripheral receiver. Consumes its byte stream (received byte + one-cycle valid strobe) and packs consecutive bytes into one WORD_WIDTH-bit word, e.g. ciphertext or vote words for the encryption datapath.
- Presents each completed word on a valid/ready handshake and holds it until consumed.
- Discards partial frames after an inter-byte timeout.
- Flags bytes that arrive while a finished word is still unconsumed.

Parameters:
- WORD_WIDTH, 64, packed word width; must be a multiple of 8 and ≥ 8. BYTES = WORD_WIDTH/8.
- MSB_FIRST, 1, 1: first received byte lands in word_out[WORD_WIDTH-1 -: 8]; 0: first byte lands in word_out[7:0].
- TIMEOUT_CYCLES, 100_000, idle clk_in cycles allowed between bytes of one frame; must be ≥ 2.

Ports:
- clk_in  input  1  system clock (100 MHz).
- rst_in  input  1  asynchronous, active-high reset.
- data_in  input  8  received byte.
- valid_in  input  1  one-cycle strobe qualifying data_in.
- ready_in  input  1  consumer accepts word_out when high with word_valid_out.
- word_out  output  WORD_WIDTH  packed word, registered.
- word_valid_out  output  1  word_out holds a complete word.
- byte_count_out  output  $clog2(BYTES+2)  bytes collected in the current frame.
- busy_out  output  1  high in COLLECT.
- timeout_out  output  1  one-cycle pulse when a partial frame is discarded.
- overflow_out  output  1  one-cycle pulse when a byte is dropped in HOLD.
- checksum_err_out  output  1  one-cycle pulse on checksum mismatch; tied 0 without the optional feature.

Behaviour:
- Reset (asynchronous, active-high):
  - State IDLE.
  - word_out = 0; word_valid_out, busy_out, timeout_out, overflow_out, checksum_err_out = 0.
  - byte_count_out = 0; timer = 0.
- States: IDLE, COLLECT, HOLD.
- IDLE:
  - valid_in stores the byte in slot 0; count = 1; timer = 0.
  - Next state is COLLECT, or HOLD directly if the frame length is 1.
- COLLECT:
  - Each valid_in stores the byte in slot count, increments count and clears the timer.
  - The byte completing the frame moves the FSM to HOLD. word_out is loaded and word_valid_out rises on the next clock edge, i.e. 1 cycle of latency after the final valid_in.
  - Cycles without valid_in increment the timer.
  - When the timer reaches TIMEOUT_CYCLES-1, on the next edge: discard the partial frame, count = 0, pulse timeout_out for 1 cycle, go to IDLE.
  - valid_in on the timeout cycle wins: byte accepted, timer cleared, no timeout.
- HOLD:
  - word_valid_out = 1; word_out stable; count = BYTES; timer frozen.
  - On word_valid_out && ready_in, word_valid_out drops next cycle, count = 0, and the FSM returns to IDLE.
  - valid_in on that same handshake cycle is accepted as slot 0 of the next frame: count = 1, state COLLECT.
  - valid_in in HOLD without ready_in: byte dropped, overflow_out pulses 1 cycle, word held unchanged.
- Slot ordering follows MSB_FIRST. Unfilled slot contents are never visible, because word_out updates only on completion.
- word_out keeps the last word after the handshake until the next completion.
- busy_out = (state == COLLECT).
- Pulse outputs are never high for two consecutive cycles from a single event.

Optional Feature:
- Macro: SPI_WORD_PACKER_CHECKSUM_EN.
- Defined:
  - Frame length is BYTES+1. The extra trailing byte must equal the XOR of the BYTES data bytes.
  - Match: word presented exactly as in HOLD above.
  - Mismatch: word discarded, checksum_err_out pulses 1 cycle, count = 0, return to IDLE; word_valid_out never asserts.
  - Completion latency is still 1 cycle after the checksum byte.
- Not defined: frame length = BYTES; no check is performed; checksum_err_out is tied 0.

Test Plan:
- WORD_WIDTH=32, MSB_FIRST=1, ready_in=1; bytes DE, AD, BE, EF with gaps of 3 cycles -> word_out=32'hDEADBEEF; word_valid_out high exactly 1 cycle, the cycle after EF's strobe; byte_count_out steps 1,2,3,4 then 0.
- MSB_FIRST=0, same bytes -> word_out=32'hEFBEADDE.
- TIMEOUT_CYCLES=16; bytes 11, 22, then 16 idle cycles -> timeout_out single pulse, byte_count_out=0, word_valid_out stays 0; then 01..04 -> 32'h01020304.
- ready_in=0; complete word 32'hCAFEF00D, then byte 55 -> overflow_out pulse, word_out unchanged; raise ready_in with byte A1 on the handshake cycle -> word consumed, byte_count_out=1, next word starts with A1.
- Assert rst_in asynchronously mid-frame, after 2 bytes -> all outputs 0 immediately without a clock edge; following 4 bytes 10..13 -> 32'h10111213.
- With SPI_WORD_PACKER_CHECKSUM_EN: bytes 01 02 03 04, checksum 04 -> word 32'h01020304 valid; same data with checksum 05 -> checksum_err_out pulse, no word_valid_out.
